// File: rtl/plot_arb_pkg.sv
// Shared constants and state encoding for the framebuffer write-port arbiter.
package plot_arb_pkg;

  localparam int X_W       = 8;
  localparam int Y_W       = 7;
  localparam int C_W       = 3;
  localparam int OWN_W     = 3;
  localparam int MAX_REQ   = 8;
  localparam int X_MAX_DEF = 159;
  localparam int Y_MAX_DEF = 119;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    CLEAR = 2'd2
  } arb_state_t;

endpackage

// File: rtl/plot_rr_select.sv
// Combinational round-robin picker: first valid requester after last_owner, with wrap.
module plot_rr_select
  import plot_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [OWN_W-1:0]   last_owner,
  output logic [OWN_W-1:0]   grant,
  output logic               any
);

  logic [MAX_REQ-1:0] valid_pad;
  logic [OWN_W-1:0]   cand [NUM_REQ];

  assign valid_pad = MAX_REQ'(req_valid);

  // cand[k] is the k-th index searched, starting just after last_owner
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    logic [OWN_W:0] sum;
    assign sum      = {1'b0, last_owner} + (OWN_W+1)'(gi + 1);
    assign cand[gi] = (sum >= (OWN_W+1)'(NUM_REQ)) ? OWN_W'(sum - (OWN_W+1)'(NUM_REQ))
                                                   : sum[OWN_W-1:0];
  end

  always_comb begin
    grant = '0;
    any   = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (valid_pad[cand[k]]) begin
        grant = cand[k];
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/plot_arbiter.sv
// Shares the VGA framebuffer write port among burst requesters (round-robin, locked
// per burst) and a built-in full-screen clear sweeper; one cycle of output latency.
module plot_arbiter
  import plot_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int X_MAX   = X_MAX_DEF,
  parameter int Y_MAX   = Y_MAX_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*X_W-1:0] req_x,
  input  logic [NUM_REQ*Y_W-1:0] req_y,
  input  logic [NUM_REQ*C_W-1:0] req_color,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic                   clear_start,
  input  logic [C_W-1:0]         clear_color,
  output logic                   clear_busy,
  output logic                   plot,
  output logic [X_W-1:0]         plot_x,
  output logic [Y_W-1:0]         plot_y,
  output logic [C_W-1:0]         color,
  output logic [OWN_W-1:0]       owner
);

  arb_state_t       state_reg, state_next;
  logic [OWN_W-1:0] owner_reg, owner_next, last_owner_reg, last_owner_next;
  logic             pending_reg, pending_next, clear_busy_reg, clear_busy_next;
  logic [C_W-1:0]   clear_color_reg, clear_color_next;
  logic [7:0]       stall_reg, stall_next;
  logic [X_W-1:0]   cx_reg, cx_next, plot_x_reg, plot_x_next;
  logic [Y_W-1:0]   cy_reg, cy_next, plot_y_reg, plot_y_next;
  logic [C_W-1:0]   color_reg, color_next;
  logic             plot_reg, plot_next;

  // Unpack requester buses into fixed 8-entry arrays so the owner index needs no width games
  logic [X_W-1:0]     x_arr [MAX_REQ];
  logic [Y_W-1:0]     y_arr [MAX_REQ];
  logic [C_W-1:0]     c_arr [MAX_REQ];
  logic [MAX_REQ-1:0] valid_pad, last_pad;

  for (genvar gi = 0; gi < MAX_REQ; gi++) begin : g_unpack
    if (gi < NUM_REQ) begin : g_real
      assign x_arr[gi]     = req_x[X_W*gi +: X_W];
      assign y_arr[gi]     = req_y[Y_W*gi +: Y_W];
      assign c_arr[gi]     = req_color[C_W*gi +: C_W];
      assign valid_pad[gi] = req_valid[gi];
      assign last_pad[gi]  = req_last[gi];
    end else begin : g_pad
      assign x_arr[gi]     = '0;
      assign y_arr[gi]     = '0;
      assign c_arr[gi]     = '0;
      assign valid_pad[gi] = 1'b0;
      assign last_pad[gi]  = 1'b0;
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign req_ready[gi] = (state_reg == BURST) && (owner_reg == OWN_W'(gi));
  end

  logic [OWN_W-1:0] rr_grant;
  logic             rr_any;

  plot_rr_select #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_valid  (req_valid),
    .last_owner (last_owner_reg),
    .grant      (rr_grant),
    .any        (rr_any)
  );

  logic xfer, in_range;
  assign xfer     = (state_reg == BURST) && valid_pad[owner_reg];
  assign in_range = (x_arr[owner_reg] <= X_W'(X_MAX)) && (y_arr[owner_reg] <= Y_W'(Y_MAX));

  always_comb begin
    state_next       = state_reg;
    owner_next       = owner_reg;
    last_owner_next  = last_owner_reg;
    pending_next     = pending_reg;
    clear_color_next = clear_color_reg;
    stall_next       = stall_reg;
    cx_next          = cx_reg;
    cy_next          = cy_reg;
    plot_next        = 1'b0;
    plot_x_next      = plot_x_reg;
    plot_y_next      = plot_y_reg;
    color_next       = color_reg;
    case (state_reg)
      IDLE: begin
        if (clear_start || pending_reg) begin
          state_next   = CLEAR;
          pending_next = 1'b1;
          cx_next      = '0;
          cy_next      = '0;
          if (clear_start) clear_color_next = clear_color;
        end else if (rr_any) begin
          state_next = BURST;
          owner_next = rr_grant;
          stall_next = '0;
        end
      end
      BURST: begin
        // A clear request waits for the burst to finish
        if (clear_start) begin
          pending_next     = 1'b1;
          clear_color_next = clear_color;
        end
        if (xfer) begin
          stall_next = '0;
          if (in_range) begin
            plot_next   = 1'b1;
            plot_x_next = x_arr[owner_reg];
            plot_y_next = y_arr[owner_reg];
            color_next  = c_arr[owner_reg];
          end
          if (last_pad[owner_reg]) begin
            state_next      = IDLE;
            last_owner_next = owner_reg;
          end
        end else begin
          stall_next = stall_reg + 8'd1;
          if (stall_reg + 8'd1 == 8'(TIMEOUT)) begin
            state_next      = IDLE;
            last_owner_next = owner_reg;
          end
        end
      end
      CLEAR: begin
        plot_next   = 1'b1;
        plot_x_next = cx_reg;
        plot_y_next = cy_reg;
        color_next  = clear_color_reg;
        if (cx_reg == X_W'(X_MAX)) begin
          cx_next = '0;
          if (cy_reg == Y_W'(Y_MAX)) begin
            state_next   = IDLE;
            pending_next = 1'b0;
          end else begin
            cy_next = cy_reg + 1'b1;
          end
        end else begin
          cx_next = cx_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    clear_busy_next = pending_next || (state_next == CLEAR);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      owner_reg       <= '0;
      last_owner_reg  <= OWN_W'(NUM_REQ - 1);
      pending_reg     <= 1'b0;
      clear_busy_reg  <= 1'b0;
      clear_color_reg <= '0;
      stall_reg       <= '0;
      cx_reg          <= '0;
      cy_reg          <= '0;
      plot_reg        <= 1'b0;
      plot_x_reg      <= '0;
      plot_y_reg      <= '0;
      color_reg       <= '0;
    end else begin
      state_reg       <= state_next;
      owner_reg       <= owner_next;
      last_owner_reg  <= last_owner_next;
      pending_reg     <= pending_next;
      clear_busy_reg  <= clear_busy_next;
      clear_color_reg <= clear_color_next;
      stall_reg       <= stall_next;
      cx_reg          <= cx_next;
      cy_reg          <= cy_next;
      plot_reg        <= plot_next;
      plot_x_reg      <= plot_x_next;
      plot_y_reg      <= plot_y_next;
      color_reg       <= color_next;
    end
  end

  assign plot       = plot_reg;
  assign plot_x     = plot_x_reg;
  assign plot_y     = plot_y_reg;
  assign color      = color_reg;
  assign owner      = owner_reg;
  assign clear_busy = clear_busy_reg;

endmodule

// File: tb/tb_plot_arbiter.sv
// Scoreboard bench for plot_arbiter: requester driver, plot monitor, directed scenarios.
module tb_plot_arbiter;

  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NR-1:0] req_valid = '0, req_last = '0, req_ready;
  logic [NR*8-1:0] req_x = '0;
  logic [NR*7-1:0] req_y = '0;
  logic [NR*3-1:0] req_color = '0;
  logic          clear_start = 1'b0, clear_busy, plot;
  logic [2:0]    clear_color = '0, color, owner;
  logic [7:0]    plot_x;
  logic [6:0]    plot_y;

  always #5 clk = ~clk;

  plot_arbiter #(.NUM_REQ(NR), .X_MAX(159), .Y_MAX(119), .TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .req_color(req_color), .req_last(req_last), .req_ready(req_ready),
    .clear_start(clear_start), .clear_color(clear_color), .clear_busy(clear_busy),
    .plot(plot), .plot_x(plot_x), .plot_y(plot_y), .color(color), .owner(owner)
  );

  typedef struct { int r; logic [7:0] x; logic [6:0] y; logic [2:0] c; logic last; } pix_t;
  typedef struct { logic [7:0] x; logic [6:0] y; logic [2:0] c; } exp_t;

  pix_t pend[$];
  exp_t exp_q[$];
  int checks = 0, failures = 0, plot_count = 0;
  int fire_cnt [NR];

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, want);
    end
  endtask

  task automatic add_pix(input int r, input int x, input int y, input int c, input bit last);
    pend.push_back('{r, 8'(x), 7'(y), 3'(c), last});
  endtask

  task automatic exp_pix(input int x, input int y, input int c);
    exp_q.push_back('{8'(x), 7'(y), 3'(c)});
  endtask

  task automatic exp_clear(input int c);
    for (int y = 0; y <= 119; y++)
      for (int x = 0; x <= 159; x++) exp_pix(x, y, c);
  endtask

  task automatic present();
    for (int i = 0; i < NR; i++) begin
      bit found;
      found = 1'b0;
      req_valid[i] = 1'b0;
      for (int j = 0; j < pend.size(); j++) begin
        if (!found && pend[j].r == i) begin
          found = 1'b1;
          req_valid[i] = 1'b1;
          req_x[8*i +: 8] = pend[j].x;
          req_y[7*i +: 7] = pend[j].y;
          req_color[3*i +: 3] = pend[j].c;
          req_last[i] = pend[j].last;
        end
      end
    end
  endtask

  // Requester driver: sample handshakes mid-cycle, retire accepted pixels after the edge
  initial begin
    logic [NR-1:0] fire;
    forever begin
      @(negedge clk);
      fire = req_valid & req_ready;
      for (int i = 0; i < NR; i++) if (fire[i]) fire_cnt[i]++;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (fire[i]) begin
          for (int j = 0; j < pend.size(); j++) begin
            if (pend[j].r == i) begin
              pend.delete(j);
              break;
            end
          end
        end
      end
      present();
    end
  end

  // Plot monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && plot) begin
        plot_count++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_plot got x=%0d y=%0d c=%0d expected none", plot_x, plot_y, color);
        end else begin
          e = exp_q.pop_front();
          if (plot_x != e.x || plot_y != e.y || color != e.c) begin
            failures++;
            $display("FAIL plot got x=%0d y=%0d c=%0d expected x=%0d y=%0d c=%0d",
                     plot_x, plot_y, color, e.x, e.y, e.c);
          end
        end
      end
    end
  end

  task automatic wait_ready(input string name, input logic [NR-1:0] mask, input int budget);
    int n = 0;
    while (req_ready !== mask && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(req_ready), int'(mask));
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((pend.size() + exp_q.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, pend.size() + exp_q.size(), 0);
  endtask

  task automatic pulse_clear(input int c);
    clear_start = 1'b1;
    clear_color = 3'(c);
    @(posedge clk);
    #1;
    clear_start = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n, stall;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_plot", plot, 0);
    chk("rst_xyc", {plot_x, plot_y, color}, 0);
    chk("rst_owner", owner, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", clear_busy, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", req_ready, 0);

    // Contention between 0 and 1, two rounds
    for (int k = 0; k < 3; k++) begin add_pix(0, 10, 20, 3, k == 2); exp_pix(10, 20, 3); end
    for (int k = 0; k < 3; k++) begin add_pix(1, 30, 40, 5, k == 2); exp_pix(30, 40, 5); end
    wait_ready("t2_grant0", 4'b0001, 20);
    chk("t2_owner0", owner, 0);
    n = 0;
    while (req_ready == 4'b0001 && n < 20) begin @(negedge clk); n++; end
    chk("t2_idle_gap", req_ready, 0);
    @(negedge clk);
    chk("t2_grant1", req_ready, 4'b0010);
    chk("t2_owner1", owner, 1);
    drain("t2_drain", 40);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin add_pix(0, 11, 21, 6, k == 1); exp_pix(11, 21, 6); end
    for (int k = 0; k < 2; k++) begin add_pix(1, 31, 41, 7, k == 1); exp_pix(31, 41, 7); end
    wait_ready("t2_regrant0", 4'b0001, 20);
    chk("t2_reowner0", owner, 0);
    drain("t2_drain2", 40);

    // Clipping: out-of-range pixels consumed without a plot
    repeat (2) @(negedge clk);
    base = fire_cnt[1];
    add_pix(1, 160, 5, 2, 0);
    add_pix(1, 5, 120, 2, 0);
    add_pix(1, 5, 5, 2, 1);
    exp_pix(5, 5, 2);
    drain("t3_drain", 40);
    chk("t3_transfers", fire_cnt[1] - base, 3);

    // Stalled owner loses lock after TIMEOUT cycles
    repeat (2) @(negedge clk);
    add_pix(0, 1, 1, 6, 0);
    exp_pix(1, 1, 6); exp_pix(70, 80, 1); exp_pix(71, 80, 1);
    wait_ready("t4_grant0", 4'b0001, 20);
    chk("t4_owner0", owner, 0);
    add_pix(2, 70, 80, 1, 0);
    add_pix(2, 71, 80, 1, 1);
    stall = 0; n = 0;
    while (req_ready[0] && n < 40) begin
      @(negedge clk);
      n++;
      if (req_ready[0] && !req_valid[0]) stall++;
    end
    chk("t4_stall_hold", stall, 8);
    wait_ready("t4_grant2", 4'b0100, 20);
    chk("t4_owner2", owner, 2);
    drain("t4_drain", 40);

    // Clear requested mid-burst waits for the burst
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin add_pix(3, 50 + k, 60, 4, k == 4); exp_pix(50 + k, 60, 4); end
    exp_clear(2);
    base = fire_cnt[3]; n = 0;
    while (fire_cnt[3] - base < 2 && n < 40) begin @(negedge clk); n++; end
    chk("t5_mid_burst", fire_cnt[3] - base, 2);
    pulse_clear(2);
    @(negedge clk);
    chk("t5_busy", clear_busy, 1);
    chk("t5_not_preempted", req_ready, 4'b1000);
    drain("t5_drain", 19400);
    chk("t5_busy_done", clear_busy, 0);

    // Clear from IDLE; a second clear_start during CLEAR is ignored
    repeat (2) @(negedge clk);
    base = plot_count;
    exp_clear(1);
    pulse_clear(1);
    @(negedge clk);
    chk("t6_busy_next", clear_busy, 1);
    repeat (50) @(negedge clk);
    pulse_clear(7);
    drain("t6_drain", 19400);
    repeat (5) @(negedge clk);
    chk("t6_busy_done", clear_busy, 0);
    chk("t6_plot_count", plot_count - base, 19200);

    // Reset in the middle of a clear
    repeat (2) @(negedge clk);
    exp_clear(6);
    pulse_clear(6);
    base = plot_count; n = 0;
    while (plot_count - base < 100 && n < 300) begin @(negedge clk); n++; end
    chk("t7_100_plots", (plot_count - base >= 100) ? 1 : 0, 1);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t7_rst_plot", plot, 0);
    chk("t7_rst_xyc", {plot_x, plot_y, color}, 0);
    chk("t7_rst_owner", owner, 0);
    chk("t7_rst_busy", clear_busy, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("t7_idle_ready", req_ready, 0);
    chk("t7_idle_busy", clear_busy, 0);
    add_pix(2, 7, 8, 2, 1);
    exp_pix(7, 8, 2);
    wait_ready("t7_grant2", 4'b0100, 20);
    chk("t7_owner2", owner, 2);
    drain("t7_drain", 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/plot_arbiter.md
Name: plot_arbiter

Overview:
- Shares the single VGA framebuffer write port (plot, plot_x, plot_y, color) among several pixel-stream requesters, e.g. ball, paddle and block draw/erase engines.
- Locks a requester for a whole burst (one sprite), rotating round-robin between bursts.
- Contains a built-in full-screen clear sweeper.
- Sits between the game datapath draw engines and the VGA adapter in the top level.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- X_MAX, 159, last valid column
- Y_MAX, 119, last valid row
- TIMEOUT, 255, idle cycles before a stalled owner loses its lock (1..255)

Ports:
- clk  in  1  system clock (CLOCK_50)
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  requester i presents a pixel
- req_x  in  NUM_REQ*8  packed x, requester i at [8i+7:8i]
- req_y  in  NUM_REQ*7  packed y
- req_color  in  NUM_REQ*3  packed colour
- req_last  in  NUM_REQ  pixel is last of burst
- req_ready  out  NUM_REQ  pixel accepted when valid&&ready
- clear_start  in  1  one-cycle request to fill screen
- clear_color  in  3  fill colour, sampled with clear_start
- clear_busy  out  1  clear pending or running
- plot  out  1  framebuffer write strobe
- plot_x  out  8  write column
- plot_y  out  7  write row
- color  out  3  write colour
- owner  out  3  index of current burst owner (valid in BURST)

Behaviour:
- Reset (async, reset_n=0): state=IDLE; plot=0, plot_x=0, plot_y=0, color=0, owner=0, req_ready=0, clear_busy=0; clear pending flag=0; last_owner=NUM_REQ-1 so requester 0 wins first.
- States: IDLE, BURST, CLEAR.
- IDLE, priority order:
  - clear_start or clear pending -> CLEAR, sweep counters cleared to (0,0).
  - Else any req_valid -> BURST, owner = first valid index searching last_owner+1 upward with wrap.
  - Else stay.
  - No pixels are accepted in IDLE, so there is one arbitration cycle per burst.
- BURST:
  - req_ready[i] = (i==owner), combinational from registered state/owner.
  - Transfer = req_valid[owner] && req_ready[owner].
  - Transfer with req_last -> IDLE, last_owner<=owner.
  - Owner valid low: stall counter increments; counter reaching TIMEOUT -> IDLE, last_owner<=owner (lock released, no plot). Any transfer clears the counter.
  - clear_start during BURST sets the pending flag and latches colour; the burst is not preempted.
- CLEAR:
  - One pixel per cycle at (cx,cy) in the latched colour.
  - cx wraps X_MAX->0 with cy+1.
  - Pixel (X_MAX,Y_MAX) emitted -> IDLE, pending cleared.
  - Total (X_MAX+1)*(Y_MAX+1) = 19200 plots.
  - clear_start during CLEAR is ignored. req_ready all 0.
- clear_busy = pending || state==CLEAR, registered; high the cycle after clear_start.
- Output latency is one cycle: a transfer or clear pixel in cycle t gives plot=1 with its x/y/colour in cycle t+1. plot=0 otherwise; plot_x/plot_y/color hold their last values.
- Clipping: an accepted pixel with x>X_MAX or y>Y_MAX is consumed (ready honoured, last honoured) but plot stays 0.
- Requester inputs are don't-care while not granted; a requester dropping valid mid-burst keeps the lock until TIMEOUT.

Decomposition:
- Package plot_arb_pkg holds:
  - state encoding IDLE=2'd0, BURST=2'd1, CLEAR=2'd2
  - screen constants (X_W=8, Y_W=7, C_W=3, defaults 159/119)
- Sub-module plot_rr_select: combinational round-robin picker (req_valid vector, last_owner -> grant index, any). It is reused by future sound/LCD sharing.
- Sweep counters and FSM stay in plot_arbiter.

Test Plan:
- Reset mid-CLEAR (after 100 plots), reset_n low 2 cycles -> all outputs 0, clear_busy=0, state IDLE; next request from requester 2 alone is granted (owner=2).
- Requesters 0 and 1 both valid, each 3-pixel bursts (0: (10,20) col 3; 1: (30,40) col 5) -> owner 0 first; plots at 10,20 x3 then IDLE cycle, then requester 1 x3; next contention grants 1 before 0 again only after 0 has had a turn.
- clear_start with clear_color=3'b001 in IDLE -> clear_busy next cycle, exactly 19200 plot pulses, first (0,0), last (159,119), row wrap at (159,y)->(0,y+1); clear_busy low after.
- clear_start during requester 3's 5-pixel burst at pixel 2 -> burst completes all 5 plots, then CLEAR starts after one IDLE cycle.
- Requester 1 sends (160,5) and (5,120) then (5,5) last -> 3 transfers, only one plot at (5,5).
- Owner 0 drops valid after pixel 1 with TIMEOUT=8 -> req_ready[0] released after 8 stall cycles; waiting requester 2 granted next.
